ex_muldiv: RTL and testbench

//  EX-stage iterative multiply/divide unit. Operands and op come from the
//  ID->EX pipeline register outputs (rs/rt data, decoded op).

---
 rtl/muldiv_pkg.sv | 31 +++
 rtl/muldiv_step.sv | 42 ++++
 rtl/ex_muldiv.sv | 185 ++++++++++++++++++
 tb/tb_ex_muldiv.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// Shared encodings for the EX-stage multiply/divide unit.
// Ops: MULT/MULTU/DIV/DIVU on 2 bits. FSM states: IDLE/RUN/DONE.
// DATA_W_DEF is the default operand / HI / LO width.
package muldiv_pkg;

    localparam int DATA_W_DEF = 32;

    typedef enum logic [1:0] {
        OP_MULT  = 2'b00,
        OP_MULTU = 2'b01,
        OP_DIV   = 2'b10,
        OP_DIVU  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_e;

    // Divides have the high op bit set.
    function automatic logic op_is_div(input op_e op);
        return (op == OP_DIV) || (op == OP_DIVU);
    endfunction

    // Signed variants have the low op bit clear.
    function automatic logic op_is_signed(input op_e op);
        return (op == OP_MULT) || (op == OP_DIV);
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the multiply/divide datapath on {acc, q}.
// Purely combinational (zero latency).
// No flow control; the owning FSM decides when the result is registered.
// Ports: is_div_i selects restoring divide vs shift-add multiply;
//        acc_i/q_i are the running state, b_i the multiplicand or divisor.
module muldiv_step
    import muldiv_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              is_div_i,
    input  logic [DATA_W-1:0] acc_i,
    input  logic [DATA_W-1:0] q_i,
    input  logic [DATA_W-1:0] b_i,
    output logic [DATA_W-1:0] acc_o,
    output logic [DATA_W-1:0] q_o
);

    logic [DATA_W:0] sum;
    logic [DATA_W:0] shifted;

    always_comb begin
        // Multiply: add multiplicand when the LSB of the multiplier is set,
        // then shift {carry, acc, q} right by one.
        sum     = {1'b0, acc_i} + ({1'b0, b_i} & {(DATA_W+1){q_i[0]}});
        // Divide: bring the next dividend bit into the partial remainder.
        shifted = {acc_i, q_i[DATA_W-1]};
        acc_o   = sum[DATA_W:1];
        q_o     = {sum[0], q_i[DATA_W-1:1]};
        if (is_div_i) begin
            if (shifted >= {1'b0, b_i}) begin
                // Remainder after a successful subtract is below b_i, so it fits.
                acc_o = shifted[DATA_W-1:0] - b_i;
                q_o   = {q_i[DATA_W-2:0], 1'b1};
            end else begin
                acc_o = shifted[DATA_W-1:0];
                q_o   = {q_i[DATA_W-2:0], 1'b0};
            end
        end
    end

endmodule

// File: rtl/ex_muldiv.sv
// EX-stage iterative MULT/MULTU/DIV/DIVU unit writing architectural HI/LO.
// Latency: 33 cycles from accepted start_i to the HI/LO update (done_o the cycle before).
// Backpressure: start_i is dropped while busy_o; flush_i aborts without touching HI/LO.
// Ports: start_i/op_i/rs_i/rt_i issue, flush_i squash, mthi_i/mtlo_i/wdata_i direct writes,
//        busy_o/done_o status to the hazard unit, hi_o/lo_o architectural registers.
module ex_muldiv
    import muldiv_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              start_i,
    input  logic [1:0]        op_i,
    input  logic [DATA_W-1:0] rs_i,
    input  logic [DATA_W-1:0] rt_i,
    input  logic              flush_i,
    input  logic              mthi_i,
    input  logic              mtlo_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic              busy_o,
    output logic              done_o,
    output logic [DATA_W-1:0] hi_o,
    output logic [DATA_W-1:0] lo_o
);

    localparam int              CNT_W    = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] acc_q, acc_d;
    logic [DATA_W-1:0] qr_q, qr_d;
    logic [DATA_W-1:0] b_q, b_d;
    logic              is_div_q, is_div_d;
    logic              neg_q, neg_d;     // negate product / quotient
    logic              rneg_q, rneg_d;   // remainder takes dividend sign
    logic              div0_q, div0_d;
    logic [DATA_W-1:0] hi_q, hi_d;
    logic [DATA_W-1:0] lo_q, lo_d;

    logic              accept;
    logic              finish;
    logic              is_div_in;
    logic              rs_neg, rt_neg;
    logic [DATA_W-1:0] abs_rs, abs_rt;
    logic [DATA_W-1:0] step_acc, step_q;
    logic [2*DATA_W-1:0] prod;
    logic [DATA_W-1:0] res_hi, res_lo;

    muldiv_step #(.DATA_W(DATA_W)) u_step (
        .is_div_i (is_div_q),
        .acc_i    (acc_q),
        .q_i      (qr_q),
        .b_i      (b_q),
        .acc_o    (step_acc),
        .q_o      (step_q)
    );

    assign accept = (state_q == ST_IDLE) && start_i && !flush_i;
    assign finish = (state_q == ST_DONE) && !flush_i;

    // FSM: state register
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        if (flush_i) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: if (start_i) state_d = ST_RUN;
                ST_RUN:  if (cnt_q == CNT_LAST) state_d = ST_DONE;
                ST_DONE: state_d = ST_IDLE;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // FSM: outputs
    always_comb begin
        busy_o = (state_q != ST_IDLE);
        done_o = (state_q == ST_DONE) && !flush_i;
    end

    // Operand conditioning: iterate on magnitudes, fix signs at the end.
    always_comb begin
        is_div_in = op_is_div(op_e'(op_i));
        rs_neg    = op_is_signed(op_e'(op_i)) && rs_i[DATA_W-1];
        rt_neg    = op_is_signed(op_e'(op_i)) && rt_i[DATA_W-1];
        abs_rs    = rs_neg ? -rs_i : rs_i;
        abs_rt    = rt_neg ? -rt_i : rt_i;
    end

    // Sign-corrected result from the final {acc, q}.
    always_comb begin
        prod = {acc_q, qr_q};
        if (neg_q) prod = -prod;
        res_hi = prod[2*DATA_W-1:DATA_W];
        res_lo = prod[DATA_W-1:0];
        if (is_div_q) begin
            res_hi = rneg_q ? -acc_q : acc_q;
            res_lo = div0_q ? {DATA_W{1'b1}} : (neg_q ? -qr_q : qr_q);
        end
    end

    // Datapath next-state
    always_comb begin
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        qr_d     = qr_q;
        b_d      = b_q;
        is_div_d = is_div_q;
        neg_d    = neg_q;
        rneg_d   = rneg_q;
        div0_d   = div0_q;
        hi_d     = hi_q;
        lo_d     = lo_q;

        if (accept) begin
            cnt_d    = '0;
            acc_d    = '0;
            // Divide iterates on the dividend; multiply shifts the multiplier.
            qr_d     = is_div_in ? abs_rs : abs_rt;
            b_d      = is_div_in ? abs_rt : abs_rs;
            is_div_d = is_div_in;
            neg_d    = rs_neg ^ rt_neg;
            rneg_d   = rs_neg;
            div0_d   = is_div_in && (rt_i == '0);
        end else if (state_q == ST_RUN) begin
            cnt_d = cnt_q + 1'b1;
            acc_d = step_acc;
            qr_d  = step_q;
        end

        // Direct writes only land while idle; a same-cycle start is later
        // overwritten by its own result.
        if (state_q == ST_IDLE) begin
            if (mthi_i) hi_d = wdata_i;
            if (mtlo_i) lo_d = wdata_i;
        end

        if (finish) begin
            hi_d = res_hi;
            lo_d = res_lo;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cnt_q    <= '0;
            acc_q    <= '0;
            qr_q     <= '0;
            b_q      <= '0;
            is_div_q <= 1'b0;
            neg_q    <= 1'b0;
            rneg_q   <= 1'b0;
            div0_q   <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
        end else begin
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            qr_q     <= qr_d;
            b_q      <= b_d;
            is_div_q <= is_div_d;
            neg_q    <= neg_d;
            rneg_q   <= rneg_d;
            div0_q   <= div0_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
        end
    end

    assign hi_o = hi_q;
    assign lo_o = lo_q;

endmodule

// File: tb/tb_ex_muldiv.sv
// Scoreboard bench for ex_muldiv: expected HI/LO queued at issue, checked by a monitor.
// Drives inputs 2 time units after the rising edge, samples on the falling edge.
// Covers arithmetic corners, flush, ignored start/mthi while busy, and async reset.
module tb_ex_muldiv;

    logic        clk_i   = 1'b0;
    logic        rst_n_i = 1'b0;
    logic        start_i = 1'b0;
    logic [1:0]  op_i    = 2'b00;
    logic [31:0] rs_i    = '0;
    logic [31:0] rt_i    = '0;
    logic        flush_i = 1'b0;
    logic        mthi_i  = 1'b0;
    logic        mtlo_i  = 1'b0;
    logic [31:0] wdata_i = '0;
    logic        busy_o;
    logic        done_o;
    logic [31:0] hi_o;
    logic [31:0] lo_o;

    ex_muldiv #(.DATA_W(32)) dut (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .start_i (start_i),
        .op_i    (op_i),
        .rs_i    (rs_i),
        .rt_i    (rt_i),
        .flush_i (flush_i),
        .mthi_i  (mthi_i),
        .mtlo_i  (mtlo_i),
        .wdata_i (wdata_i),
        .busy_o  (busy_o),
        .done_o  (done_o),
        .hi_o    (hi_o),
        .lo_o    (lo_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        int          id;
        logic [31:0] hi;
        logic [31:0] lo;
    } exp_t;

    exp_t exp_q[$];
    exp_t cur;
    bit   pending = 1'b0;
    int   checks   = 0;
    int   failures = 0;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: done_o marks the cycle before HI/LO update; compare one cycle later.
    always @(negedge clk_i) begin
        if (pending) begin
            pending = 1'b0;
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_result: got hi=%h lo=%h expected no result", hi_o, lo_o);
            end else begin
                cur = exp_q.pop_front();
                check32($sformatf("op%0d_hi", cur.id), hi_o, cur.hi);
                check32($sformatf("op%0d_lo", cur.id), lo_o, cur.lo);
                check32($sformatf("op%0d_done_width", cur.id), {31'b0, done_o}, 32'd0);
            end
        end
        if (done_o) pending = 1'b1;
    end

    // Vector table: op, rs, rt, expected HI, expected LO
    localparam int NV = 9;
    logic [1:0]  v_op [NV] = '{2'b01, 2'b00, 2'b10, 2'b11, 2'b11, 2'b10, 2'b10, 2'b00, 2'b10};
    logic [31:0] v_rs [NV] = '{32'hFFFFFFFF, 32'hFFFFFFFD, 32'hFFFFFFF9, 32'd100, 32'd5,
                               32'h80000000, 32'hFFFFFFFB, 32'h7FFFFFFF, 32'd7};
    logic [31:0] v_rt [NV] = '{32'hFFFFFFFF, 32'd7, 32'd2, 32'd7, 32'd0,
                               32'hFFFFFFFF, 32'd0, 32'h80000000, 32'hFFFFFFFE};
    logic [31:0] v_hi [NV] = '{32'hFFFFFFFE, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd2, 32'd5,
                               32'h00000000, 32'hFFFFFFFB, 32'hC0000000, 32'd1};
    logic [31:0] v_lo [NV] = '{32'h00000001, 32'hFFFFFFEB, 32'hFFFFFFFD, 32'd14, 32'hFFFFFFFF,
                               32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'hFFFFFFFD};

    task automatic run_op(input int id, input logic [1:0] op, input logic [31:0] rs, input logic [31:0] rt,
                          input logic [31:0] ehi, input logic [31:0] elo,
                          input bit inj, input logic [31:0] phi, input logic [31:0] plo);
        int n;
        bit fin;
        @(posedge clk_i); #2;
        start_i = 1'b1; op_i = op; rs_i = rs; rt_i = rt;
        exp_q.push_back('{id, ehi, elo});
        @(posedge clk_i); #2;
        // Operands must have been captured at the start edge.
        start_i = 1'b0; rs_i = 32'hDEADBEEF; rt_i = 32'h0BADF00D;
        n = 0;
        fin = 1'b0;
        for (int k = 0; k < 100 && !fin; k++) begin
            @(negedge clk_i);
            if (busy_o) begin
                n++;
                if (inj && n == 5) begin
                    @(posedge clk_i); #2;
                    start_i = 1'b1; op_i = 2'b11; rs_i = 32'd9; rt_i = 32'd3;
                    mthi_i = 1'b1; mtlo_i = 1'b1; wdata_i = 32'h00001234;
                end
                if (inj && n == 6) begin
                    check32($sformatf("op%0d_mthi_ignored", id), hi_o, phi);
                    check32($sformatf("op%0d_mtlo_ignored", id), lo_o, plo);
                    @(posedge clk_i); #2;
                    start_i = 1'b0; mthi_i = 1'b0; mtlo_i = 1'b0;
                end
            end else begin
                fin = 1'b1;
            end
        end
        check32($sformatf("op%0d_busy_cycles", id), n, 32'd33);
    endtask

    task automatic mt_write(input logic [31:0] hv, input logic [31:0] lv);
        @(posedge clk_i); #2;
        mthi_i = 1'b1; wdata_i = hv;
        @(posedge clk_i); #2;
        mthi_i = 1'b0; mtlo_i = 1'b1; wdata_i = lv;
        @(posedge clk_i); #2;
        mtlo_i = 1'b0;
        @(negedge clk_i);
        check32("mthi", hi_o, hv);
        check32("mtlo", lo_o, lv);
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (3) @(posedge clk_i);
        #2;
        check32("reset_hi", hi_o, 32'd0);
        check32("reset_lo", lo_o, 32'd0);
        check32("reset_busy", {31'b0, busy_o}, 32'd0);
        check32("reset_done", {31'b0, done_o}, 32'd0);
        rst_n_i = 1'b1;

        for (int i = 0; i < NV; i++) begin
            run_op(i, v_op[i], v_rs[i], v_rt[i], v_hi[i], v_lo[i], 1'b0, 32'd0, 32'd0);
        end

        // MULTU with a mid-op start and MTHI/MTLO that must be ignored.
        run_op(NV, 2'b01, 32'h12345678, 32'h10, 32'd1, 32'h23456780,
               1'b1, v_hi[NV-1], v_lo[NV-1]);

        // Flush during RUN: HI/LO keep the directly written values.
        mt_write(32'h000000AA, 32'h00000055);
        @(posedge clk_i); #2;
        start_i = 1'b1; op_i = 2'b00; rs_i = 32'd2; rt_i = 32'd3;
        @(posedge clk_i); #2;
        start_i = 1'b0;
        repeat (9) @(posedge clk_i);
        #2;
        flush_i = 1'b1;
        @(posedge clk_i); #2;
        flush_i = 1'b0;
        @(negedge clk_i);
        check32("flush_busy", {31'b0, busy_o}, 32'd0);
        repeat (40) @(posedge clk_i);
        @(negedge clk_i);
        check32("flush_hi", hi_o, 32'h000000AA);
        check32("flush_lo", lo_o, 32'h00000055);

        // Flush in IDLE blocks a same-cycle start.
        @(posedge clk_i); #2;
        start_i = 1'b1; flush_i = 1'b1; op_i = 2'b01; rs_i = 32'd4; rt_i = 32'd4;
        @(posedge clk_i); #2;
        start_i = 1'b0; flush_i = 1'b0;
        @(negedge clk_i);
        check32("flush_idle_busy", {31'b0, busy_o}, 32'd0);

        // Async reset mid-op clears HI/LO at once.
        mt_write(32'h00000011, 32'h00000022);
        @(posedge clk_i); #2;
        start_i = 1'b1; op_i = 2'b01; rs_i = 32'd3; rt_i = 32'd3;
        @(posedge clk_i); #2;
        start_i = 1'b0;
        repeat (4) @(posedge clk_i);
        #2;
        rst_n_i = 1'b0;
        #1;
        check32("arst_hi", hi_o, 32'd0);
        check32("arst_lo", lo_o, 32'd0);
        check32("arst_busy", {31'b0, busy_o}, 32'd0);
        #4;
        rst_n_i = 1'b1;
        repeat (40) @(posedge clk_i);
        @(negedge clk_i);
        check32("arst_hold_hi", hi_o, 32'd0);
        check32("arst_hold_lo", lo_o, 32'd0);

        repeat (3) @(posedge clk_i);
        check32("scoreboard_empty", exp_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
